// File: rtl/shift_arbiter_if.sv
// Request/response bundle between two shift requesters and the shared shift arbiter.
// The arbiter owns the slave side; requesters (or a bench) use the master side.
interface shift_arbiter_if #(
    parameter int NBITS = 4
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [NBITS-1:0] req0_a;
    logic [NBITS-1:0] req0_b;
    logic             req0_dir;
    logic [NBITS-1:0] req1_a;
    logic [NBITS-1:0] req1_b;
    logic             req1_dir;
    logic [1:0]       resp_valid;
    logic [1:0]       resp_ready;
    logic [NBITS-1:0] resp_data;

    modport master (
        output req_valid, req0_a, req0_b, req0_dir, req1_a, req1_b, req1_dir, resp_ready,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req0_a, req0_b, req0_dir, req1_a, req1_b, req1_dir, resp_ready,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one logical left/right barrel shifter between two
// requesters; one operation in flight, result returned on the owner's response channel.
module shift_arbiter #(
    parameter int NBITS = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    shift_arbiter_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]       r_state;
    logic             r_rr_ptr;
    logic             r_owner;
    logic [NBITS-1:0] r_a;
    logic [NBITS-1:0] r_b;
    logic             r_dir;
    logic [NBITS-1:0] r_data;

    logic             w_grant;
    logic [1:0]       w_req_ready;
    logic             w_accept;
    logic [NBITS-1:0] w_shl;
    logic [NBITS-1:0] w_shr;

    // The pointed-to requester wins if it is asking, otherwise the other one does.
    assign w_grant = bus.req_valid[r_rr_ptr] ? r_rr_ptr : ~r_rr_ptr;

    // NOTE: assign a default before any condition so always_comb never infers a latch.
    always_comb begin
        w_req_ready = 2'b00;
        if (rst_n && (r_state == S_IDLE) && (|bus.req_valid))
            w_req_ready = w_grant ? 2'b10 : 2'b01;
    end

    assign w_accept = |(bus.req_valid & w_req_ready);

    // Log-stage barrel shifter; a stage of width >= NBITS clears the word.
    always_comb begin
        w_shl = r_a;
        w_shr = r_a;
        for (int i = 0; i < NBITS; i++) begin
            if (r_b[i]) begin
                w_shl = w_shl << (2 ** i);
                w_shr = w_shr >> (2 ** i);
            end
        end
    end

    // NOTE: registers use non-blocking assignments so all of them sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= 1'b0;
            r_owner  <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_dir    <= 1'b0;
            r_data   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a      <= w_grant ? bus.req1_a   : bus.req0_a;
                        r_b      <= w_grant ? bus.req1_b   : bus.req0_b;
                        r_dir    <= w_grant ? bus.req1_dir : bus.req0_dir;
                        r_owner  <= w_grant;
                        r_rr_ptr <= ~w_grant;
                        r_state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_data  <= r_dir ? w_shr : w_shl;
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    if (bus.resp_ready[r_owner])
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.resp_valid = (r_state == S_RESP) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
    assign bus.resp_data  = r_data;

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: directed literal cases plus randomized traffic, all
// compared every cycle against a transaction-level model of the arbiter.
module tb_shift_arbiter;
    localparam int NBITS = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    shift_arbiter_if #(.NBITS(NBITS)) bus ();
    shift_arbiter #(.NBITS(NBITS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Transaction-level model: one op outstanding, result visible one edge after accept.
    bit               m_busy  = 1'b0;
    bit               m_vis   = 1'b0;
    bit               m_rr    = 1'b0;
    bit               m_owner = 1'b0;
    logic [NBITS-1:0] m_result = '0;
    int               m_done   = 0;
    int               dut_resp = 0;

    function automatic logic [1:0] oh(input logic k);
        return k ? 2'b10 : 2'b01;
    endfunction

    function automatic bit model_grant(input logic [1:0] v, input bit rr);
        return v[rr] ? rr : !rr;
    endfunction

    function automatic logic [NBITS-1:0] shift_ref(input logic [NBITS-1:0] a,
                                                   input logic [NBITS-1:0] b,
                                                   input logic dir);
        int unsigned ai, bi, r;
        ai = a;
        bi = b;
        if (bi >= NBITS) return '0;
        r = dir ? (ai >> bi) : (ai << bi);
        return r[NBITS-1:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : model
        bit g;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_busy = 1'b0; m_vis = 1'b0; m_rr = 1'b0; m_owner = 1'b0;
            end else if (!m_busy) begin
                if (|bus.req_valid) begin
                    g        = model_grant(bus.req_valid, m_rr);
                    m_owner  = g;
                    m_result = g ? shift_ref(bus.req1_a, bus.req1_b, bus.req1_dir)
                                 : shift_ref(bus.req0_a, bus.req0_b, bus.req0_dir);
                    m_rr     = !g;
                    m_busy   = 1'b1;
                end
            end else if (!m_vis) begin
                m_vis = 1'b1;
            end else if (bus.resp_ready[m_owner]) begin
                m_busy = 1'b0;
                m_vis  = 1'b0;
                m_done++;
            end
        end
    end

    initial begin : compare
        logic [1:0] er, ev;
        forever begin
            @(negedge clk);
            er = (rst_n && !m_busy && (|bus.req_valid)) ? oh(model_grant(bus.req_valid, m_rr)) : 2'b00;
            ev = (rst_n && m_vis) ? oh(m_owner) : 2'b00;
            check("req_ready", 32'(bus.req_ready), 32'(er));
            check("resp_valid", 32'(bus.resp_valid), 32'(ev));
            if (rst_n && m_vis)
                check("resp_data", 32'(bus.resp_data), 32'(m_result));
            else if (!rst_n)
                check("resp_data_reset", 32'(bus.resp_data), 32'd0);
            if (|(bus.resp_valid & bus.resp_ready)) dut_resp++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_valid = 2'b00;
        bus.req0_a = '0; bus.req0_b = '0; bus.req0_dir = 1'b0;
        bus.req1_a = '0; bus.req1_b = '0; bus.req1_dir = 1'b0;
        bus.resp_ready = 2'b00;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic run_op(input bit k, input logic [NBITS-1:0] a, input logic [NBITS-1:0] b,
                          input logic dir, input logic [NBITS-1:0] exp, input string name);
        step();
        bus.req_valid = oh(k);
        if (k) begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_dir = dir;
        end else begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_dir = dir;
        end
        bus.resp_ready = oh(k);
        @(negedge clk);
        check({name, "_ready"}, 32'(bus.req_ready), 32'(oh(k)));
        step();
        bus.req_valid = 2'b00;
        @(negedge clk);
        check({name, "_exec_valid"}, 32'(bus.resp_valid), 32'd0);
        step();
        @(negedge clk);
        check({name, "_valid"}, 32'(bus.resp_valid), 32'(oh(k)));
        check({name, "_data"}, 32'(bus.resp_data), 32'(exp));
        step();
        @(negedge clk);
        check({name, "_done"}, 32'(bus.resp_valid), 32'd0);
    endtask

    task automatic wait_resp(input string name);
        bit seen;
        seen = 1'b0;
        for (int cyc = 0; cyc < 8 && !seen; cyc++) begin
            step();
            @(negedge clk);
            if (bus.resp_valid != 2'b00) seen = 1'b1;
        end
        check({name, "_seen"}, 32'(seen), 32'd1);
    endtask

    function automatic logic [NBITS-1:0] rand_amt();
        if ($urandom_range(0, 3) == 0) return NBITS'($urandom);
        return NBITS'($urandom_range(0, NBITS - 1));
    endfunction

    initial begin : main
        int start;
        idle_inputs();
        rst_n = 1'b0;
        step();
        bus.req_valid = 2'b11;
        @(negedge clk);
        check("reset_req_ready", 32'(bus.req_ready), 32'd0);
        check("reset_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("reset_resp_data", 32'(bus.resp_data), 32'd0);
        do_reset();

        run_op(1'b0, 4'b0011, 4'd1, 1'b0, 4'b0110, "left");
        run_op(1'b1, 4'b1000, 4'd3, 1'b1, 4'b0001, "right");
        run_op(1'b0, 4'b1011, 4'd4, 1'b0, 4'b0000, "ovf_left");
        run_op(1'b1, 4'b1011, 4'd4, 1'b1, 4'b0000, "ovf_right");
        run_op(1'b0, 4'b1011, 4'd0, 1'b1, 4'b1011, "zero_amt");
        run_op(1'b1, 4'b0110, 4'd15, 1'b0, 4'b0000, "max_amt");

        // Round-robin with both requesters always asking.
        do_reset();
        bus.req0_a = 4'b0001; bus.req0_b = 4'd1; bus.req0_dir = 1'b0;
        bus.req1_a = 4'b1000; bus.req1_b = 4'd1; bus.req1_dir = 1'b1;
        bus.resp_ready = 2'b11;
        bus.req_valid  = 2'b11;
        for (int op = 0; op < 8; op++) begin
            wait_resp("rr");
            check("rr_owner", 32'(bus.resp_valid), (op % 2 != 0) ? 32'd2 : 32'd1);
            check("rr_data", 32'(bus.resp_data), (op % 2 != 0) ? 32'h4 : 32'h2);
        end
        step();
        idle_inputs();
        repeat (3) step();

        // Response backpressure on requester 1.
        bus.req1_a = 4'b0101; bus.req1_b = 4'd1; bus.req1_dir = 1'b0;
        bus.req_valid = 2'b10;
        wait_resp("bp");
        for (int i = 0; i < 5; i++) begin
            step();
            bus.req_valid = 2'b11;
            @(negedge clk);
            check("bp_hold_valid", 32'(bus.resp_valid), 32'd2);
            check("bp_hold_data", 32'(bus.resp_data), 32'hA);
            check("bp_hold_ready", 32'(bus.req_ready), 32'd0);
        end
        step();
        bus.resp_ready = 2'b10;
        step();
        @(negedge clk);
        check("bp_idle_valid", 32'(bus.resp_valid), 32'd0);
        check("bp_idle_ready", 32'(bus.req_ready), 32'd1);
        step();
        idle_inputs();
        bus.resp_ready = 2'b11;
        repeat (5) step();

        // Reset while the op is executing.
        bus.req0_a = 4'b0011; bus.req0_b = 4'd2; bus.req0_dir = 1'b0;
        bus.req_valid = 2'b01;
        bus.resp_ready = 2'b01;
        step();
        check("exec_req_ready", 32'(bus.req_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("midrst_req_ready", 32'(bus.req_ready), 32'd0);
        check("midrst_resp_data", 32'(bus.resp_data), 32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        bus.req_valid = 2'b11;
        #1;
        check("postrst_rr", 32'(bus.req_ready), 32'd1);
        step();
        idle_inputs();
        bus.resp_ready = 2'b11;
        repeat (5) step();

        // Randomized traffic.
        start = dut_resp;
        for (int cyc = 0; cyc < 20000 && dut_resp < start + 1000; cyc++) begin
            step();
            bus.req_valid  = 2'($urandom | $urandom);
            bus.req0_a     = NBITS'($urandom);
            bus.req0_b     = rand_amt();
            bus.req0_dir   = 1'($urandom);
            bus.req1_a     = NBITS'($urandom);
            bus.req1_b     = rand_amt();
            bus.req1_dir   = 1'($urandom);
            bus.resp_ready = 2'($urandom | $urandom);
        end
        check("random_ops_done", 32'(dut_resp - start >= 1000), 32'd1);
        step();
        idle_inputs();
        bus.resp_ready = 2'b11;
        repeat (6) step();
        @(negedge clk);
        check("no_lost_resp", 32'(dut_resp), 32'(m_done));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
